// File: rtl/fifo_pkg.sv
// Shared constants and sizing helper for the synchronous FIFO.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 8;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read with enable.
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AW         = addr_w(DEF_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_we,
   input  logic [AW-1:0]         i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [AW-1:0]         i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Storage is deliberately left out of reset; only the read register clears.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrapping pointers, occupancy count and flags around a register array.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = addr_w(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_wr_acc;
   logic          w_rd_acc;

   assign w_full   = (r_count == FULL_CNT);
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = wr_en && !w_full;
   assign w_rd_acc = rd_en && !w_empty;

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
         if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk     (clk),
      .rstn    (rstn),
      .i_we    (w_wr_acc),
      .i_waddr (r_wptr),
      .i_wdata (data_in),
      .i_re    (w_rd_acc),
      .i_raddr (r_rptr),
      .o_rdata (data_out)
   );

   assign full  = w_full;
   assign empty = w_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with hand-computed expectations per scenario.
module tb_sync_fifo;

   logic       clk;
   logic       rstn;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;

   int total = 0;
   int bad   = 0;

   sync_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .data_in  (data_in),
      .data_out (data_out),
      .full     (full),
      .empty    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
      #50;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", data_out); end
      rstn = 1'b1;
      tick();
      total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL release_flags got e=%b f=%b want e=1 f=0", empty, full); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; data_in = 8'hA0 + 8'(i);
         tick();
         total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty i=%0d got=%b want=0", i, empty); end
         total++; if (full !== (i == 7)) begin bad++; $display("FAIL fill_full i=%0d got=%b want=%b", i, full, (i == 7)); end
      end
      data_in = 8'hFF;
      tick();
      total++; if (full !== 1'b1) begin bad++; $display("FAIL overflow_full got=%b want=1", full); end
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL overflow_dout got=%h want=00", data_out); end
      wr_en = 1'b0;
   endtask

   task automatic test_drain();
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         tick();
         total++; if (data_out !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h want=%h", i, data_out, 8'hA0 + 8'(i)); end
         total++; if (empty !== (i == 7)) begin bad++; $display("FAIL drain_empty i=%0d got=%b want=%b", i, empty, (i == 7)); end
         total++; if (full !== 1'b0) begin bad++; $display("FAIL drain_full i=%0d got=%b want=0", i, full); end
      end
      tick();
      total++; if (data_out !== 8'hA7) begin bad++; $display("FAIL underflow_dout got=%h want=a7", data_out); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL underflow_empty got=%b want=1", empty); end
      rd_en = 1'b0;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; data_in = 8'h50 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd_en = 1'b1;
         tick();
         total++; if (data_out !== 8'h50 + 8'(i)) begin bad++; $display("FAIL wrap_pre i=%0d got=%h want=%h", i, data_out, 8'h50 + 8'(i)); end
      end
      rd_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; data_in = 8'h10 + 8'(i);
         tick();
         total++; if (full !== (i == 7)) begin bad++; $display("FAIL wrap_full i=%0d got=%b want=%b", i, full, (i == 7)); end
      end
      wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         tick();
         total++; if (data_out !== 8'h10 + 8'(i)) begin bad++; $display("FAIL wrap_data i=%0d got=%h want=%h", i, data_out, 8'h10 + 8'(i)); end
      end
      rd_en = 1'b0;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", empty); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; data_in = 8'h30 + 8'(i);
         tick();
      end
      // Steady state with 3 entries: each cycle pops the oldest and pushes a new one.
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h33 + 8'(i);
         tick();
         total++; if (data_out !== 8'h30 + 8'(i)) begin bad++; $display("FAIL simul_data i=%0d got=%h want=%h", i, data_out, 8'h30 + 8'(i)); end
         total++; if (empty !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL simul_flags i=%0d got e=%b f=%b want e=0 f=0", i, empty, full); end
      end
      wr_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1;
         tick();
         total++; if (data_out !== 8'h34 + 8'(i)) begin bad++; $display("FAIL simul_drain i=%0d got=%h want=%h", i, data_out, 8'h34 + 8'(i)); end
      end
      rd_en = 1'b0;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL simul_empty got=%b want=1", empty); end

      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; data_in = 8'h60 + 8'(i);
         tick();
      end
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h99;
      tick();
      total++; if (data_out !== 8'h60) begin bad++; $display("FAIL fullboth_data got=%h want=60", data_out); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL fullboth_full got=%b want=0", full); end
      wr_en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         total++; if (data_out !== 8'h61 + 8'(i)) begin bad++; $display("FAIL fullboth_drain i=%0d got=%h want=%h", i, data_out, 8'h61 + 8'(i)); end
      end
      rd_en = 1'b0;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL fullboth_empty got=%b want=1", empty); end

      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
      tick();
      total++; if (data_out !== 8'h67) begin bad++; $display("FAIL emptyboth_dout got=%h want=67", data_out); end
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL emptyboth_empty got=%b want=0", empty); end
      wr_en = 1'b0;
      tick();
      total++; if (data_out !== 8'h77) begin bad++; $display("FAIL emptyboth_read got=%h want=77", data_out); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL emptyboth_after got=%b want=1", empty); end
      rd_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; data_in = 8'h40 + 8'(i);
         tick();
      end
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      total++; if (data_out !== 8'h40) begin bad++; $display("FAIL mid_pre got=%h want=40", data_out); end
      rstn = 1'b0;
      #2;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b want=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL mid_full got=%b want=0", full); end
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_dout got=%h want=00", data_out); end
      #2;
      rstn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wr_en = 1'b1; data_in = 8'hC0 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_en = 1'b1;
         tick();
         total++; if (data_out !== 8'hC0 + 8'(i)) begin bad++; $display("FAIL mid_new i=%0d got=%h want=%h", i, data_out, 8'hC0 + 8'(i)); end
      end
      rd_en = 1'b0;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_end_empty got=%b want=1", empty); end
      tick();
      total++; if (data_out !== 8'hC1) begin bad++; $display("FAIL mid_hold got=%h want=c1", data_out); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock synchronous FIFO buffer of DEPTH words, each DATA_WIDTH bits wide.
It sits between a producer and a consumer in the same clock domain and decouples their rates using write/read enables plus full/empty status.
Storage is a register-array memory indexed by wrapping read and write pointers.

Parameters:
DATA_WIDTH, 8, width of each stored word in bits.
DEPTH, 8, number of entries; must be a power of two and at least 2.

Ports:
clk  input  1  rising-edge clock for all state.
rstn  input  1  asynchronous active-low reset.
wr_en  input  1  write request; sampled on the rising edge of clk.
rd_en  input  1  read request; sampled on the rising edge of clk.
data_in  input  DATA_WIDTH  write data, captured when a write is accepted.
data_out  output  DATA_WIDTH  registered read data.
full  output  1  high when DEPTH entries are stored.
empty  output  1  high when 0 entries are stored.

Behaviour:
- Reset: while rstn is low, regardless of clk:
  - write pointer, read pointer and count clear to 0;
  - data_out is 0, empty is 1, full is 0;
  - memory contents are not cleared.
- Reset asserted mid-operation discards all stored data immediately.
- Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 back to 0.
- Count is $clog2(DEPTH)+1 bits wide and ranges over 0..DEPTH.
- Accepted write (wr_en && !full): mem[wptr] <= data_in; wptr advances by 1.
- Accepted read (rd_en && !empty): data_out <= mem[rptr]; rptr advances by 1. Read data therefore appears one cycle after the rd_en edge.
- data_out holds its last value on any cycle without an accepted read.
- Overflow (wr_en while full): write ignored; memory and pointers unchanged; no error flag.
- Underflow (rd_en while empty): read ignored; data_out and pointers unchanged.
- Simultaneous wr_en and rd_en:
  - neither full nor empty: both are accepted and count is unchanged;
  - full: only the read is accepted;
  - empty: only the write is accepted, with no fall-through, so data_out is not updated that cycle.
- Count update: +1 on a write-only cycle, -1 on a read-only cycle, unchanged otherwise.
- full = (count == DEPTH) and empty = (count == 0), both decoded combinationally from the count register. Flags reflect the state after the clock edge.
- Order is strictly first-in first-out across pointer wrap-around.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_WIDTH and DEPTH constants;
  - function addr_w(depth) returning $clog2(depth).
- One natural sub-module, sync_fifo_mem: a simple dual-port register array with a synchronous write port and a registered read port that has a read enable.
- Pointer, count and flag logic stay in sync_fifo.

Test Plan:
- Reset: hold rstn=0 for 50 time units with wr_en=rd_en=0 -> empty=1, full=0, data_out=0. Release reset -> flags unchanged.
- Fill: write 0xA0..0xA7 on consecutive cycles -> empty falls after the first edge, full rises after the 8th. A 9th write of 0xFF leaves full=1 and changes no contents.
- Drain: read 8 times -> data_out = 0xA0..0xA7 in order, each one cycle after its rd_en edge, and empty=1 after the 8th. A 9th read holds data_out=0xA7.
- Wrap-around: write 5 words, read 5, write 0x10..0x17, read 8 -> output is exactly 0x10..0x17 and full asserts correctly despite the pointer wrap.
- Simultaneous access:
  - with 3 entries, wr_en=rd_en=1 for 4 cycles -> count stays 3 and data stays in order;
  - when full, both asserted -> one word is read and full drops;
  - when empty, both asserted -> one word is stored and data_out is unchanged.
- Reset mid-operation: store 4 words, then pulse rstn low between clock edges -> empty=1 and data_out=0 immediately. Subsequent writes and reads return only the new data.
